fp_sqrt_resp_buffer: RTL and testbench

- Result buffer directly downstream of the DesignWare fp-sqrt wrapper.
- The sqrt unit never stalls: its Ready is tied high and its results are pushed unconditionally.
- This block captures every Valid result (Res/Tag/Status) into a FIFO and presents it to the APU interconnect with a valid/ready handshake.
- It issues credits upstream so the arbiter never launches more sqrt ops than the FIFO can absorb.

---
 rtl/apu_cluster_package.sv | 12 +
 rtl/apu_sync_fifo.sv | 49 ++++
 rtl/fp_sqrt_resp_buffer.sv | 106 ++++++++++
 tb/tb_fp_sqrt_resp_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/apu_cluster_package.sv
// Shared APU cluster constants and response types for the FP sqrt result path.
package apu_cluster_package;

  localparam int unsigned FP_WIDTH      = 32;
  localparam int unsigned NUSFLAGS_SQRT = 5;

  typedef struct packed {
    logic [FP_WIDTH-1:0]      res;
    logic [NUSFLAGS_SQRT-1:0] status;
  } sqrt_resp_t;

endpackage

// File: rtl/apu_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; storage cleared on reset.
// Pushes into a full FIFO are dropped unless a pop frees a slot in the same cycle.
module apu_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic                        do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fp_sqrt_resp_buffer.sv
// Credit-managed result buffer behind the non-stalling fp-sqrt wrapper.
// Optional FP_SQRT_RESP_BYPASS_EN lets a result reach the consumer in its arrival cycle when empty.
module fp_sqrt_resp_buffer
  import apu_cluster_package::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_WIDTH  = 0,
  parameter int unsigned STAT_WIDTH = NUSFLAGS_SQRT
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     Issue_i,
  output logic                                     Ready_o,
  input  logic                                     ValidIn_i,
  input  logic [FP_WIDTH-1:0]                      ResIn_i,
  input  logic [((TAG_WIDTH > 0) ? TAG_WIDTH : 1)-1:0] TagIn_i,
  input  logic [STAT_WIDTH-1:0]                    StatusIn_i,
  output logic                                     Valid_o,
  input  logic                                     Ready_i,
  output logic [FP_WIDTH-1:0]                      Res_o,
  output logic [((TAG_WIDTH > 0) ? TAG_WIDTH : 1)-1:0] Tag_o,
  output logic [STAT_WIDTH-1:0]                    Status_o,
  output logic                                     Err_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned TW = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
  localparam int unsigned DW = FP_WIDTH + STAT_WIDTH + TAG_WIDTH;

  logic [DW-1:0]         fifo_din, fifo_dout;
  logic                  fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]         count_q, inflight_q, inflight_d;
  logic [FP_WIDTH-1:0]   head_res;
  logic [STAT_WIDTH-1:0] head_stat;
  logic [TW-1:0]         head_tag, in_tag;
  logic                  issue_ok, ret_ok, spurious, overflow, err_q;

  // The tag field only exists in storage when the instance actually carries a tag.
  if (TAG_WIDTH > 0) begin : g_tag
    assign in_tag                          = TagIn_i;
    assign fifo_din                        = {ResIn_i, StatusIn_i, TagIn_i};
    assign {head_res, head_stat, head_tag} = fifo_dout;
  end else begin : g_notag
    logic unused_tag;
    assign unused_tag            = ^TagIn_i;
    assign in_tag                = '0;
    assign fifo_din              = {ResIn_i, StatusIn_i};
    assign {head_res, head_stat} = fifo_dout;
    assign head_tag              = '0;
  end

  apu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (fifo_din),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_q)
  );

`ifdef FP_SQRT_RESP_BYPASS_EN
  assign Valid_o  = ~fifo_empty | ValidIn_i;
  assign Res_o    = fifo_empty ? ResIn_i    : head_res;
  assign Tag_o    = fifo_empty ? in_tag     : head_tag;
  assign Status_o = fifo_empty ? StatusIn_i : head_stat;
  // A result taken straight off the input is never written.
  assign push     = ValidIn_i & ~(fifo_empty & Ready_i);
  assign pop      = ~fifo_empty & Ready_i;
`else
  logic unused_in_tag;
  assign unused_in_tag = ^in_tag;
  assign Valid_o  = ~fifo_empty;
  assign Res_o    = head_res;
  assign Tag_o    = head_tag;
  assign Status_o = head_stat;
  assign push     = ValidIn_i;
  assign pop      = Valid_o & Ready_i;
`endif

  // Credit check sees only registered occupancy, so Ready_o has no input path.
  assign Ready_o  = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
  assign issue_ok = Issue_i & Ready_o;
  assign ret_ok   = ValidIn_i & ((inflight_q != '0) | issue_ok);
  assign spurious = ValidIn_i & ~ret_ok;
  assign overflow = push & fifo_full & ~pop;

  assign inflight_d = inflight_q + {{(CW-1){1'b0}}, issue_ok} - {{(CW-1){1'b0}}, ret_ok};
  assign Err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_q | (Issue_i & ~Ready_o) | spurious | overflow;
    end
  end

endmodule

// File: tb/tb_fp_sqrt_resp_buffer.sv
// Directed bench for fp_sqrt_resp_buffer at DEPTH=4, TAG_WIDTH=4.
module tb_fp_sqrt_resp_buffer;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        Issue_i = 1'b0, ValidIn_i = 1'b0, Ready_i = 1'b0;
  logic [31:0] ResIn_i = '0;
  logic [3:0]  TagIn_i = '0;
  logic [4:0]  StatusIn_i = '0;
  logic        Ready_o, Valid_o, Err_o;
  logic [31:0] Res_o;
  logic [3:0]  Tag_o;
  logic [4:0]  Status_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fp_sqrt_resp_buffer #(.DEPTH(4), .TAG_WIDTH(4), .STAT_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .Issue_i(Issue_i), .Ready_o(Ready_o),
    .ValidIn_i(ValidIn_i), .ResIn_i(ResIn_i), .TagIn_i(TagIn_i), .StatusIn_i(StatusIn_i),
    .Valid_o(Valid_o), .Ready_i(Ready_i), .Res_o(Res_o), .Tag_o(Tag_o),
    .Status_o(Status_o), .Err_o(Err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  task automatic idle;
    Issue_i = 0; ValidIn_i = 0; ResIn_i = '0; TagIn_i = '0; StatusIn_i = '0;
  endtask

  task automatic do_reset;
    idle(); Ready_i = 0; rst_ni = 0;
    tick(); tick();
    rst_ni = 1;
    tick();
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      Issue_i = 1; tick();
    end
    Issue_i = 0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    chk_cnt++; if (Valid_o !== 1'b0) $display("FAIL rst_valid got %0h exp 0", Valid_o); else pass_cnt++;
    chk_cnt++; if (Res_o !== 32'h0) $display("FAIL rst_res got %0h exp 0", Res_o); else pass_cnt++;
    chk_cnt++; if (Tag_o !== 4'h0) $display("FAIL rst_tag got %0h exp 0", Tag_o); else pass_cnt++;
    chk_cnt++; if (Status_o !== 5'h0) $display("FAIL rst_status got %0h exp 0", Status_o); else pass_cnt++;
    chk_cnt++; if (Err_o !== 1'b0) $display("FAIL rst_err got %0h exp 0", Err_o); else pass_cnt++;
    chk_cnt++; if (Ready_o !== 1'b1) $display("FAIL rst_ready got %0h exp 1", Ready_o); else pass_cnt++;
  endtask

  task automatic test_basic;
    Issue_i = 1; #1;
    chk_cnt++; if (Ready_o !== 1'b1) $display("FAIL basic_ready_pre got %0h exp 1", Ready_o); else pass_cnt++;
    tick(); Issue_i = 0;
    tick();
    ValidIn_i = 1; ResIn_i = 32'h3FC0_0000; TagIn_i = 4'h5; StatusIn_i = 5'h01; Ready_i = 0;
`ifndef FP_SQRT_RESP_BYPASS_EN
    #1;
    chk_cnt++; if (Valid_o !== 1'b0) $display("FAIL basic_no_early_valid got %0h exp 0", Valid_o); else pass_cnt++;
`endif
    tick(); idle(); Ready_i = 1; #1;
    chk_cnt++; if (Valid_o !== 1'b1) $display("FAIL basic_valid got %0h exp 1", Valid_o); else pass_cnt++;
    chk_cnt++; if (Res_o !== 32'h3FC0_0000) $display("FAIL basic_res got %0h exp 3fc00000", Res_o); else pass_cnt++;
    chk_cnt++; if (Tag_o !== 4'h5) $display("FAIL basic_tag got %0h exp 5", Tag_o); else pass_cnt++;
    chk_cnt++; if (Status_o !== 5'h01) $display("FAIL basic_status got %0h exp 1", Status_o); else pass_cnt++;
    tick(); #1;
    chk_cnt++; if (Valid_o !== 1'b0) $display("FAIL basic_drained got %0h exp 0", Valid_o); else pass_cnt++;
    chk_cnt++; if (Ready_o !== 1'b1) $display("FAIL basic_ready_post got %0h exp 1", Ready_o); else pass_cnt++;
    chk_cnt++; if (Err_o !== 1'b0) $display("FAIL basic_err got %0h exp 0", Err_o); else pass_cnt++;
    Ready_i = 0;
  endtask

  task automatic test_credit;
    Ready_i = 0;
    issue_n(4); #1;
    chk_cnt++; if (Ready_o !== 1'b0) $display("FAIL credit_exhausted got %0h exp 0", Ready_o); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      ValidIn_i = 1; TagIn_i = 4'(i); ResIn_i = 32'h100 + 32'(i); #1;
      chk_cnt++; if (Ready_o !== 1'b0) $display("FAIL credit_hold%0d got %0h exp 0", i, Ready_o); else pass_cnt++;
      tick();
    end
    idle(); #1;
    chk_cnt++; if (dut.count_q !== 3'd4) $display("FAIL credit_count got %0d exp 4", dut.count_q); else pass_cnt++;
    chk_cnt++; if (Ready_o !== 1'b0) $display("FAIL credit_full_ready got %0h exp 0", Ready_o); else pass_cnt++;
    Ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_cnt++; if (Tag_o !== 4'(i) || Valid_o !== 1'b1) $display("FAIL credit_order%0d got tag %0h v %0h exp tag %0h v 1", i, Tag_o, Valid_o, i); else pass_cnt++;
      chk_cnt++; if (Res_o !== 32'h100 + 32'(i)) $display("FAIL credit_res%0d got %0h exp %0h", i, Res_o, 32'h100 + i); else pass_cnt++;
      if (i > 0) begin
        chk_cnt++; if (Ready_o !== 1'b1) $display("FAIL credit_return%0d got %0h exp 1", i, Ready_o); else pass_cnt++;
      end
      tick();
    end
    #1;
    chk_cnt++; if (Valid_o !== 1'b0) $display("FAIL credit_empty got %0h exp 0", Valid_o); else pass_cnt++;
    chk_cnt++; if (Err_o !== 1'b0) $display("FAIL credit_err got %0h exp 0", Err_o); else pass_cnt++;
    Ready_i = 0;
  endtask

  task automatic test_full_push_pop;
    logic [3:0] exp_tags [4];
    exp_tags = '{4'h8, 4'h9, 4'hA, 4'hB};
    Ready_i = 0;
    issue_n(4);
    for (int i = 0; i < 3; i++) begin
      ValidIn_i = 1; TagIn_i = exp_tags[i]; ResIn_i = 32'hA000 + 32'(i); tick();
    end
    idle(); #1;
    chk_cnt++; if (dut.count_q !== 3'd3 || dut.inflight_q !== 3'd1) $display("FAIL full_setup got count %0d inflight %0d exp 3 1", dut.count_q, dut.inflight_q); else pass_cnt++;
    ValidIn_i = 1; TagIn_i = exp_tags[3]; ResIn_i = 32'hA003; Ready_i = 1; #1;
    chk_cnt++; if (Tag_o !== 4'h8) $display("FAIL full_head got %0h exp 8", Tag_o); else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++; if (dut.count_q !== 3'd3) $display("FAIL full_count got %0d exp 3", dut.count_q); else pass_cnt++;
    chk_cnt++; if (Err_o !== 1'b0) $display("FAIL full_err got %0h exp 0", Err_o); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk_cnt++; if (Tag_o !== exp_tags[i] || Res_o !== 32'hA000 + 32'(i)) $display("FAIL full_wrap%0d got tag %0h res %0h exp tag %0h res %0h", i, Tag_o, Res_o, exp_tags[i], 32'hA000 + i); else pass_cnt++;
      tick();
    end
    #1;
    chk_cnt++; if (Valid_o !== 1'b0) $display("FAIL full_empty got %0h exp 0", Valid_o); else pass_cnt++;
    Ready_i = 0;
  endtask

  task automatic test_issue_violation;
    Ready_i = 0;
    issue_n(4);
    Issue_i = 1; #1;
    chk_cnt++; if (Ready_o !== 1'b0) $display("FAIL viol_ready got %0h exp 0", Ready_o); else pass_cnt++;
    tick(); Issue_i = 0; #1;
    chk_cnt++; if (Err_o !== 1'b1) $display("FAIL viol_err got %0h exp 1", Err_o); else pass_cnt++;
    chk_cnt++; if (dut.inflight_q !== 3'd4) $display("FAIL viol_inflight got %0d exp 4", dut.inflight_q); else pass_cnt++;
    Ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      ValidIn_i = 1; TagIn_i = 4'(i); tick();
    end
    idle(); tick(); tick(); #1;
    chk_cnt++; if (Err_o !== 1'b1) $display("FAIL viol_sticky got %0h exp 1", Err_o); else pass_cnt++;
    chk_cnt++; if (Valid_o !== 1'b0 || dut.inflight_q !== 3'd0) $display("FAIL viol_drain got v %0h inflight %0d exp 0 0", Valid_o, dut.inflight_q); else pass_cnt++;
    do_reset(); #1;
    chk_cnt++; if (Err_o !== 1'b0) $display("FAIL viol_clear got %0h exp 0", Err_o); else pass_cnt++;
  endtask

  task automatic test_spurious;
    Ready_i = 0;
    ValidIn_i = 1; TagIn_i = 4'h7; ResIn_i = 32'h4000_0000; StatusIn_i = 5'h02;
    tick(); idle(); #1;
    chk_cnt++; if (Err_o !== 1'b1) $display("FAIL spur_err got %0h exp 1", Err_o); else pass_cnt++;
    chk_cnt++; if (Valid_o !== 1'b1 || Tag_o !== 4'h7 || Res_o !== 32'h4000_0000) $display("FAIL spur_data got v %0h tag %0h res %0h exp 1 7 40000000", Valid_o, Tag_o, Res_o); else pass_cnt++;
    chk_cnt++; if (dut.inflight_q !== 3'd0) $display("FAIL spur_inflight got %0d exp 0", dut.inflight_q); else pass_cnt++;
    Ready_i = 1; tick(); #1;
    chk_cnt++; if (Valid_o !== 1'b0 || Ready_o !== 1'b1) $display("FAIL spur_drain got v %0h r %0h exp 0 1", Valid_o, Ready_o); else pass_cnt++;
    Ready_i = 0;
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    issue_n(2);
    for (int i = 0; i < 2; i++) begin
      ValidIn_i = 1; TagIn_i = 4'hC + 4'(i); ResIn_i = 32'hDEAD_0000 + 32'(i); tick();
    end
    idle(); #1;
    chk_cnt++; if (Valid_o !== 1'b1 || dut.count_q !== 3'd2) $display("FAIL rmd_setup got v %0h count %0d exp 1 2", Valid_o, dut.count_q); else pass_cnt++;
    rst_ni = 0; #1;
    chk_cnt++; if (Valid_o !== 1'b0 || Res_o !== 32'h0) $display("FAIL rmd_async got v %0h res %0h exp 0 0", Valid_o, Res_o); else pass_cnt++;
    tick(); rst_ni = 1; Ready_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk_cnt++; if (Valid_o !== 1'b0 || Ready_o !== 1'b1 || Res_o !== 32'h0 || Tag_o !== 4'h0) $display("FAIL rmd_stale%0d got v %0h r %0h res %0h tag %0h exp 0 1 0 0", i, Valid_o, Ready_o, Res_o, Tag_o); else pass_cnt++;
    end
    Ready_i = 0;
  endtask

`ifdef FP_SQRT_RESP_BYPASS_EN
  task automatic test_bypass;
    issue_n(1);
    ValidIn_i = 1; TagIn_i = 4'h3; ResIn_i = 32'h3F80_0000; Ready_i = 1; #1;
    chk_cnt++; if (Valid_o !== 1'b1 || Res_o !== 32'h3F80_0000 || Tag_o !== 4'h3) $display("FAIL byp_same_cycle got v %0h res %0h tag %0h exp 1 3f800000 3", Valid_o, Res_o, Tag_o); else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++; if (dut.count_q !== 3'd0 || Valid_o !== 1'b0) $display("FAIL byp_no_write got count %0d v %0h exp 0 0", dut.count_q, Valid_o); else pass_cnt++;
    Ready_i = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_full_push_pop();
    test_issue_violation();
    test_spurious();
    test_reset_mid_drain();
`ifdef FP_SQRT_RESP_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
